// File: rtl/ice40_ram_bank_pkg.sv
// Shared types and helpers for the ice40_ram_bank block RAM wrapper.
// ICE40_RAM_BANK_PARITY_EN adds one stored even-parity bit per lane.
package ice40_ram_bank_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

`ifdef ICE40_RAM_BANK_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    function automatic int calc_nlane(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    // Callers zero-extend a lane into the 64-bit argument; zeros do not change the XOR.
    function automatic logic lane_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ice40_ram_bank_array.sv
// Plain storage: lane-masked write port and registered read port, no reset on
// the array or the read register so the tools can map it onto block RAM.
module ice40_ram_bank_array
    import ice40_ram_bank_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int LANE_SW = 8,
    parameter int NLANE   = 2
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [NLANE*LANE_SW-1:0] wdata,
    input  logic [NLANE-1:0]         wmask,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        raddr,
    output logic [NLANE*LANE_SW-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [NLANE*LANE_SW-1:0] mem [DEPTH];

    // Read happens before the write lands (read-first); the top level forwards.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NLANE; i++) begin
                if (wmask[i]) begin
                    mem[waddr][i*LANE_SW +: LANE_SW] <= wdata[i*LANE_SW +: LANE_SW];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ice40_ram_bank.sv
// Simple-dual-port RAM bank with lane masks, per-lane write-first forwarding,
// read-valid strobe and clear sequencer. ICE40_RAM_BANK_PARITY_EN enables parity.
module ice40_ram_bank
    import ice40_ram_bank_pkg::*;
#(
    parameter int              DATA_W         = 16,
    parameter int              ADDR_W         = 11,
    parameter int              LANE_W         = 8,
    parameter int              CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0,
    localparam int             NLANE          = calc_nlane(DATA_W, LANE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              clear_req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NLANE-1:0]  wr_mask,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_perr
);

    localparam int     DEPTH     = 2 ** ADDR_W;
    localparam int     SW        = LANE_W + PAR_BITS;
    localparam int     MW        = NLANE * SW;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    if (DATA_W % LANE_W != 0) begin : g_bad_lane
        $fatal(1, "ice40_ram_bank: DATA_W must be a multiple of LANE_W");
    end

    state_t              state_reg;
    logic                ready_reg;
    logic [ADDR_W-1:0]   cnt_reg;
    logic                rd_valid_reg;
    logic                have_data_reg;
    logic [NLANE-1:0]    fwd_mask_reg;
    logic [DATA_W-1:0]   fwd_data_reg;

    logic                wr_go;
    logic                rd_go;
    logic                arr_we;
    logic [ADDR_W-1:0]   arr_waddr;
    logic [MW-1:0]       arr_wdata;
    logic [NLANE-1:0]    arr_wmask;
    logic [MW-1:0]       arr_rdata;
    logic [MW-1:0]       wr_packed;
    logic [MW-1:0]       clr_packed;
    logic [NLANE-1:0]    lane_err;

    assign wr_go = ready_reg & wr_en;
    assign rd_go = ready_reg & rd_en;

    // Pack user and clear words into the stored layout, and unpack the read word.
    for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
        logic [LANE_W-1:0] q_lane;
        assign wr_packed[gi*SW +: LANE_W]  = wr_data[gi*LANE_W +: LANE_W];
        assign clr_packed[gi*SW +: LANE_W] = CLEAR_VALUE[gi*LANE_W +: LANE_W];
        assign q_lane = arr_rdata[gi*SW +: LANE_W];
        assign rd_data[gi*LANE_W +: LANE_W] =
            !have_data_reg   ? '0 :
            fwd_mask_reg[gi] ? fwd_data_reg[gi*LANE_W +: LANE_W] : q_lane;
`ifdef ICE40_RAM_BANK_PARITY_EN
        assign wr_packed[gi*SW + LANE_W] =
            lane_parity(64'(wr_data[gi*LANE_W +: LANE_W]));
        assign clr_packed[gi*SW + LANE_W] =
            lane_parity(64'(CLEAR_VALUE[gi*LANE_W +: LANE_W]));
        // Forwarded lanes carry fresh data whose parity is correct by construction.
        assign lane_err[gi] = !fwd_mask_reg[gi] &
            (arr_rdata[gi*SW + LANE_W] ^ lane_parity(64'(q_lane)));
`else
        assign lane_err[gi] = 1'b0;
`endif
    end

`ifdef ICE40_RAM_BANK_PARITY_EN
    assign rd_perr = rd_valid_reg & (|lane_err);
`else
    assign rd_perr = 1'b0;
`endif

    always_comb begin
        arr_we    = wr_go;
        arr_waddr = wr_addr;
        arr_wdata = wr_packed;
        arr_wmask = wr_mask;
        if (state_reg == ST_CLEAR) begin
            arr_we    = 1'b1;
            arr_waddr = cnt_reg;
            arr_wdata = clr_packed;
            arr_wmask = '1;
        end
    end

    ice40_ram_bank_array #(
        .ADDR_W  (ADDR_W),
        .LANE_SW (SW),
        .NLANE   (NLANE)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .wmask (arr_wmask),
        .re    (rd_go),
        .raddr (rd_addr),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RST_STATE;
            ready_reg     <= (RST_STATE == ST_IDLE);
            cnt_reg       <= '0;
            rd_valid_reg  <= 1'b0;
            have_data_reg <= 1'b0;
            fwd_mask_reg  <= '0;
            fwd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= rd_go;
            if (rd_go) begin
                have_data_reg <= 1'b1;
                fwd_data_reg  <= wr_data;
                fwd_mask_reg  <= (wr_go && (wr_addr == rd_addr)) ? wr_mask : '0;
            end
            case (state_reg)
                ST_CLEAR: begin
                    if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg <= ST_IDLE;
                        ready_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        state_reg <= ST_CLEAR;
                        ready_reg <= 1'b0;
                        cnt_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = ready_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_ice40_ram_bank.sv
// Bench for ice40_ram_bank (ADDR_W=4, CLEAR_VALUE=A5A5): reference model plus
// table vectors feed a scoreboard checked one cycle after each accepted read.
module tb_ice40_ram_bank;

    localparam int          ADDR_W = 4;
    localparam int          DATA_W = 16;
    localparam int          DEPTH  = 16;
    localparam logic [15:0] CV     = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready;
    logic        clear_req = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_mask = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_perr;

    always #5 clk = ~clk;

    ice40_ram_bank #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .LANE_W         (8),
        .CLEAR_ON_RESET (1),
        .CLEAR_VALUE    (CV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ready     (ready),
        .clear_req (clear_req),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_perr   (rd_perr)
    );

    typedef struct {
        logic [15:0] data;
        logic        perr;
    } exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  wm;
        logic        re;
        logic [3:0]  ra;
        logic [15:0] exp;
    } vec_t;

    exp_t        sb[$];
    logic [15:0] model_mem [DEPTH];
    logic        model_ready = 1'b0;
    logic [3:0]  model_cnt = '0;
    logic [15:0] last_data = '0;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs [12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        chk("ready", 16'(ready), 16'(model_ready));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd_valid", 16'(rd_valid), 16'd1);
            chk("rd_data", rd_data, e.data);
            chk("rd_perr", 16'(rd_perr), 16'(e.perr));
            last_data = e.data;
            $display("read  data=%h perr=%b valid=%b", rd_data, rd_perr, rd_valid);
        end else begin
            chk("rd_valid_idle", 16'(rd_valid), 16'd0);
            chk("rd_data_hold", rd_data, last_data);
        end
    endtask

    // One clock: drive at negedge, update the model, check at the following negedge.
    task automatic step(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic [1:0] wm, input logic re, input logic [3:0] ra,
                        input logic cr, input logic use_exp, input logic [15:0] exp_d,
                        input logic exp_p);
        exp_t e;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_en = re; rd_addr = ra; clear_req = cr;
        if (model_ready) begin
            if (re) begin
                e.data = model_mem[ra];
                for (int l = 0; l < 2; l++)
                    if (we && wa == ra && wm[l]) e.data[l*8 +: 8] = wd[l*8 +: 8];
                e.perr = 1'b0;
                if (use_exp) begin
                    e.data = exp_d;
                    e.perr = exp_p;
                end
                sb.push_back(e);
            end
            if (we)
                for (int l = 0; l < 2; l++)
                    if (wm[l]) model_mem[wa][l*8 +: 8] = wd[l*8 +: 8];
            if (cr) begin
                model_ready = 1'b0;
                model_cnt   = '0;
            end
        end else begin
            model_mem[model_cnt] = CV;
            if (model_cnt == 4'(DEPTH - 1)) model_ready = 1'b1;
            model_cnt = model_cnt + 4'd1;
        end
        @(negedge clk);
        $display("step  we=%b wa=%0d wd=%h wm=%b re=%b ra=%0d clr=%b ready=%b",
                 we, wa, wd, wm, re, ra, cr, ready);
        check_outputs();
    endtask

    task automatic idle_steps(input int n, input logic noisy);
        for (int i = 0; i < n; i++)
            step(noisy, 4'($urandom_range(0, 15)), 16'($urandom), 2'b11,
                 noisy, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++)
            step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a), 1'b0, 1'b1, CV, 1'b0);
    endtask

    task automatic model_reset();
        model_ready = 1'b0;
        model_cnt   = '0;
        last_data   = '0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'd3, 16'h1234, 2'b11, 1'b0, 4'd0, 16'h0000};
        vecs[1]  = '{1'b1, 4'd3, 16'hABCD, 2'b10, 1'b0, 4'd0, 16'h0000};
        vecs[2]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 16'hAB34};
        vecs[3]  = '{1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, 4'd0, 16'h0000};
        vecs[4]  = '{1'b1, 4'd5, 16'hBEEF, 2'b01, 1'b1, 4'd5, 16'h11EF};
        vecs[5]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 16'h11EF};
        vecs[6]  = '{1'b1, 4'd6, 16'h5678, 2'b00, 1'b1, 4'd6, 16'hA5A5};
        vecs[7]  = '{1'b1, 4'd7, 16'h0F0F, 2'b11, 1'b1, 4'd8, 16'hA5A5};
        vecs[8]  = '{1'b1, 4'd7, 16'hCAFE, 2'b10, 1'b1, 4'd7, 16'hCA0F};
        vecs[9]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd7, 16'hCA0F};
        vecs[10] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 16'hAB34};
        vecs[11] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 16'h0000};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", 16'(ready), 16'd0);
        chk("rst_rd_valid", 16'(rd_valid), 16'd0);
        chk("rst_rd_data", rd_data, 16'h0000);
        chk("rst_rd_perr", 16'(rd_perr), 16'd0);
        rst_n = 1'b1;

        // Clear after reset: ready rises on the 16th edge; traffic meanwhile is ignored.
        idle_steps(DEPTH, 1'b1);
        read_all();

        for (int v = 0; v < 12; v++)
            step(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].wm,
                 vecs[v].re, vecs[v].ra, 1'b0, 1'b1, vecs[v].exp, 1'b0);

        // clear_req with a same-cycle write and read, which are still performed.
        step(1'b1, 4'd9, 16'hDEAD, 2'b11, 1'b1, 4'd3, 1'b1, 1'b1, 16'hAB34, 1'b0);
        idle_steps(DEPTH, 1'b1);
        read_all();

        // Reset at clear cycle 7: outputs drop immediately, full clear afterwards.
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0, 1'b0);
        idle_steps(6, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midclr_ready", 16'(ready), 16'd0);
        chk("midclr_rd_valid", 16'(rd_valid), 16'd0);
        chk("midclr_rd_data", rd_data, 16'h0000);
        chk("midclr_rd_perr", 16'(rd_perr), 16'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_steps(DEPTH, 1'b1);
        read_all();

`ifdef ICE40_RAM_BANK_PARITY_EN
        step(1'b1, 4'd2, 16'h00FF, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0);
        dut.u_array.mem[2][0] = ~dut.u_array.mem[2][0];
        model_mem[2] = 16'h00FE;
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd2, 1'b0, 1'b1, 16'h00FE, 1'b1);
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd4, 1'b0, 1'b1, CV, 1'b0);
`endif

        idle_steps(2, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ice40_ram_bank.md
Name: ice40_ram_bank

Overview:
- Parametrised synchronous simple-dual-port RAM bank: one write port and one read port on a single clock.
- Generalised successor to the fixed 2048x2 iCE40 cell wrapper, with configurable width and depth.
- Adds per-lane write masks, read-during-write forwarding, a read-valid strobe and a hardware clear sequencer.
- Sits between a tiny1 core (or DMA engine) and on-chip block RAM; the array maps onto SB_RAM40_4K tiles.

Parameters:
- DATA_W, 16: word width in bits; must be a multiple of LANE_W.
- ADDR_W, 11: address width; DEPTH = 2**ADDR_W.
- LANE_W, 8: bits per write-mask lane; NLANE = DATA_W/LANE_W.
- CLEAR_ON_RESET, 1: 1 = run the clear sequence automatically after reset.
- CLEAR_VALUE, 0: DATA_W-bit value written by the clear sequence.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ready  out  1  high = accepting reads and writes.
- clear_req  in  1  one-cycle pulse that starts a clear; only honoured when ready=1.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_mask  in  NLANE  active-high lane enables; lane i covers bits [i*LANE_W +: LANE_W].
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse that qualifies rd_data.
- rd_perr  out  1  parity error flag, qualified by rd_valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data=0, rd_valid=0, rd_perr=0, clear counter=0.
  - State=CLEAR and ready=0 if CLEAR_ON_RESET=1; otherwise state=IDLE and ready=1.
  - Array contents are not reset.
- FSM states:
  - CLEAR: writes CLEAR_VALUE (all lanes) to address cnt each cycle and increments cnt. When cnt=DEPTH-1 is written, the next state is IDLE, ready rises to 1 and cnt returns to 0. Clear takes exactly DEPTH cycles.
  - IDLE: serves ports. clear_req=1 moves to CLEAR on the next edge, with ready=0 from that edge. Any access presented in the same cycle as clear_req is still performed.
- While ready=0:
  - wr_en and rd_en are ignored; no write happens and rd_valid stays 0.
  - rd_data holds its value; a read issued in the last IDLE cycle still returns its data.
- Reset asserted mid-clear: the sequence restarts from address 0 after release (when CLEAR_ON_RESET=1).
- Write: on the edge with wr_en=1 and ready=1, lanes with wr_mask[i]=1 are updated; other lanes keep their old value. wr_mask=0 is a legal no-op.
- Read: rd_en=1 in cycle N gives rd_data and rd_valid=1 in cycle N+1.
  - With rd_en=0, rd_valid=0 and rd_data holds its last value.
  - Back-to-back reads give one result per cycle.
- Read-during-write to the same address in the same cycle:
  - rd_data returns the new data for masked-in lanes and the old data for the other lanes (write-first per lane).
  - Different addresses do not interact.
- Elaboration check: DATA_W % LANE_W != 0 is a fatal error.

Optional Feature:
- Macro: ICE40_RAM_BANK_PARITY_EN.
- When defined:
  - The array stores one even-parity bit per lane, computed from wr_data on write and from CLEAR_VALUE during clear.
  - On a read, rd_perr = OR over lanes of stored-versus-recomputed parity mismatch, registered alongside rd_data and valid only with rd_valid.
  - Forwarded lanes use the fresh parity.
- When undefined: no parity storage exists and rd_perr is tied to 0.

Decomposition:
- Package ice40_ram_bank_pkg holds:
  - the state enum {ST_CLEAR, ST_IDLE};
  - a function computing NLANE;
  - a parity function (XOR reduction per lane).
- One sub-module, ice40_ram_bank_array: the plain storage (array, lane-masked write, registered read).
- The top level holds the FSM, clear counter, forwarding mux, parity check and valid generation.

Test Plan:
- Reset clear: CLEAR_ON_RESET=1, ADDR_W=4, CLEAR_VALUE=16'hA5A5; release reset -> ready rises exactly 16 cycles later; reads of 0..15 all return A5A5 with rd_valid one cycle after each rd_en.
- Masked write: write 16'h1234 mask 2'b11 to addr 3, then 16'hABCD mask 2'b10 -> read addr 3 returns 16'hAB34.
- Read-during-write: same cycle, write 16'hBEEF mask 2'b01 to addr 5 (old value 16'h1111) and read addr 5 -> next cycle rd_data=16'h11EF, rd_valid=1.
- clear_req in IDLE: ready drops next cycle; wr_en during CLEAR is ignored; after DEPTH cycles all addresses equal CLEAR_VALUE.
- Reset mid-clear: assert rst_n=0 at clear cycle 7 -> outputs go to 0 immediately; after release, ready rises after a full DEPTH cycles.
- Parity (macro defined): write 16'h00FF to addr 2, force a flip of the stored array bit 0 -> read addr 2 gives rd_perr=1 with rd_valid; an untouched address gives rd_perr=0.
